// File: rtl/ft_usb_pkg.sv
// Shared FT232H USB constants: byte width, output queue depth and the TX state encoding.
package ft_usb_pkg;

  localparam int unsigned FT_BYTE_W      = 8;
  localparam int unsigned FT_QUEUE_DEPTH = 3;
  localparam int unsigned FT_QCNT_W      = 2;
  localparam int unsigned FT_STAT_W      = 32;

  typedef logic [FT_BYTE_W-1:0] ft_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx_byte_queue.sv
// Three-entry circular byte queue; push and pop may occur in the same cycle.
module tx_byte_queue
  import ft_usb_pkg::*;
(
  input  logic                 clk_60m,
  input  logic                 rst_n,
  input  logic                 push,
  input  ft_byte_t             push_data,
  input  logic                 pop,
  output ft_byte_t             head_c,
  output ft_byte_t             head_after_pop_c,
  output logic [FT_QCNT_W-1:0] q_count
);

  localparam int unsigned PTR_W = 2;

  ft_byte_t         mem [FT_QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FT_QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy update
  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_count <= q_count + FT_QCNT_W'(push) - FT_QCNT_W'(pop);
    end
  end

  always_ff @(posedge clk_60m) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_c = mem[rd_ptr];

  // Byte that becomes head if the current head pops; with one entry left it is the byte being pushed
  assign head_after_pop_c = (q_count > FT_QCNT_W'(1)) ? mem[ptr_inc(rd_ptr)] : push_data;

endmodule

// File: rtl/ft232h_sync_tx.sv
// FT232H 245-synchronous FIFO transmitter: FIFO reader, output queue, WR#/SIWU# FSM.
// Define FT_TX_STATS_EN to build the accepted-byte and stall-cycle counters.
module ft232h_sync_tx
  import ft_usb_pkg::*;
#(
  parameter int unsigned FLUSH_IDLE_CYCLES = 6000
) (
  input  logic                 clk_60m,
  input  logic                 rst_n,
  input  logic [FT_BYTE_W-1:0] fifo_data_in,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 tx_enable,
  input  logic                 usb_txe_n,
  output logic                 usb_wr_n,
  output logic [FT_BYTE_W-1:0] usb_data_out,
  output logic                 usb_data_oe,
  output logic                 usb_siwu_n,
  output logic                 usb_rd_n,
  output logic                 usb_oe_n,
  output logic                 tx_busy,
  output logic [FT_STAT_W-1:0] tx_byte_cnt,
  output logic [FT_STAT_W-1:0] tx_stall_cnt
);

  localparam int unsigned IDLE_W = (FLUSH_IDLE_CYCLES > 1) ? $clog2(FLUSH_IDLE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX =
    IDLE_W'((FLUSH_IDLE_CYCLES == 0) ? 0 : FLUSH_IDLE_CYCLES - 1);
  localparam bit FLUSH_EN = (FLUSH_IDLE_CYCLES != 0);

  tx_state_e            state;
  tx_state_e            state_d;
  logic                 run_q;
  logic                 rd_pending;
  logic                 push;
  logic                 pop;
  logic                 accept;
  ft_byte_t             head_c;
  ft_byte_t             head_after_pop_c;
  logic [FT_QCNT_W-1:0] q_count;
  logic [FT_QCNT_W-1:0] q_count_nxt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 dirty;
  logic                 wr_n_d;
  logic                 siwu_n_d;
  logic                 data_oe_d;
  ft_byte_t             data_d;

  assign accept      = ~usb_wr_n & ~usb_txe_n;
  assign push        = rd_pending;
  assign pop         = accept;
  assign q_count_nxt = q_count + FT_QCNT_W'(push) - FT_QCNT_W'(pop);

  // Read credit counts the in-flight byte so the queue can never overflow; run_q masks reads in reset
  assign fifo_rd_en = run_q & tx_enable & ~fifo_empty &
                      ((3'(q_count) + 3'(rd_pending)) < 3'(FT_QUEUE_DEPTH));

  assign usb_rd_n = 1'b1;
  assign usb_oe_n = 1'b1;

  tx_byte_queue u_queue (
    .clk_60m          (clk_60m),
    .rst_n            (rst_n),
    .push             (push),
    .push_data        (fifo_data_in),
    .pop              (pop),
    .head_c           (head_c),
    .head_after_pop_c (head_after_pop_c),
    .q_count          (q_count)
  );

  // State and bus output registers
  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      usb_wr_n     <= 1'b1;
      usb_siwu_n   <= 1'b1;
      usb_data_out <= '0;
      usb_data_oe  <= 1'b0;
    end else begin
      state        <= state_d;
      usb_wr_n     <= wr_n_d;
      usb_siwu_n   <= siwu_n_d;
      usb_data_out <= data_d;
      usb_data_oe  <= data_oe_d;
    end
  end

  // Next state and next bus values; data only changes on an accept or on IDLE->SEND
  always_comb begin
    state_d   = state;
    wr_n_d    = usb_wr_n;
    siwu_n_d  = 1'b1;
    data_oe_d = usb_data_oe;
    data_d    = usb_data_out;
    case (state)
      ST_IDLE: begin
        wr_n_d    = 1'b1;
        data_oe_d = 1'b0;
        if (q_count != '0) begin
          state_d   = ST_SEND;
          wr_n_d    = 1'b0;
          data_oe_d = 1'b1;
          data_d    = head_c;
        end else if (FLUSH_EN && dirty && (idle_cnt == IDLE_MAX)) begin
          state_d  = ST_FLUSH;
          siwu_n_d = 1'b0;
        end
      end
      ST_SEND: begin
        wr_n_d    = 1'b0;
        data_oe_d = 1'b1;
        if (accept) begin
          if ((q_count == FT_QCNT_W'(1)) && !push) begin
            state_d   = ST_IDLE;
            wr_n_d    = 1'b1;
            data_oe_d = 1'b0;
          end else begin
            data_d = head_after_pop_c;
          end
        end
      end
      ST_FLUSH: begin
        wr_n_d    = 1'b1;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        wr_n_d    = 1'b1;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // Read pipeline, idle timer, flush bookkeeping and busy flag
  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      rd_pending <= 1'b0;
      idle_cnt   <= '0;
      dirty      <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      rd_pending <= fifo_rd_en;
      tx_busy    <= (q_count_nxt != '0) | fifo_rd_en;
      if (accept || (q_count != '0)) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (state == ST_FLUSH) begin
        dirty <= 1'b0;
      end else if (accept) begin
        dirty <= 1'b1;
      end
    end
  end

`ifdef FT_TX_STATS_EN
  logic                 stall;
  logic [FT_STAT_W-1:0] byte_cnt_q;
  logic [FT_STAT_W-1:0] stall_cnt_q;

  assign stall = ~usb_wr_n & usb_txe_n;

  always_ff @(posedge clk_60m or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) byte_cnt_q  <= byte_cnt_q + FT_STAT_W'(1);
      if (stall)  stall_cnt_q <= stall_cnt_q + FT_STAT_W'(1);
    end
  end

  assign tx_byte_cnt  = byte_cnt_q;
  assign tx_stall_cnt = stall_cnt_q;
`else
  assign tx_byte_cnt  = 32'd0;
  assign tx_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ft232h_sync_tx.sv
// Bench for ft232h_sync_tx: behavioural source FIFO, byte scoreboard and per-scenario tasks.
module tb_ft232h_sync_tx;

  localparam int unsigned FLUSH_CYC = 16;
`ifdef FT_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_60m = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  fifo_data_in = 8'd0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx_enable = 1'b0;
  logic        usb_txe_n = 1'b1;
  logic        usb_wr_n;
  logic [7:0]  usb_data_out;
  logic        usb_data_oe;
  logic        usb_siwu_n;
  logic        usb_rd_n;
  logic        usb_oe_n;
  logic        tx_busy;
  logic [31:0] tx_byte_cnt;
  logic [31:0] tx_stall_cnt;

  int tests = 0;
  int fails = 0;

  always #8 clk_60m = ~clk_60m;

  ft232h_sync_tx #(.FLUSH_IDLE_CYCLES(FLUSH_CYC)) dut (
    .clk_60m      (clk_60m),
    .rst_n        (rst_n),
    .fifo_data_in (fifo_data_in),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .tx_enable    (tx_enable),
    .usb_txe_n    (usb_txe_n),
    .usb_wr_n     (usb_wr_n),
    .usb_data_out (usb_data_out),
    .usb_data_oe  (usb_data_oe),
    .usb_siwu_n   (usb_siwu_n),
    .usb_rd_n     (usb_rd_n),
    .usb_oe_n     (usb_oe_n),
    .tx_busy      (tx_busy),
    .tx_byte_cnt  (tx_byte_cnt),
    .tx_stall_cnt (tx_stall_cnt)
  );

  // Standard-mode source FIFO: dout valid the cycle after rd_en; reset discards its contents
  logic [7:0]  fifo_mem [1024];
  int unsigned wptr = 0;
  int unsigned rptr = 0;
  assign fifo_empty = (wptr == rptr);

  always @(posedge clk_60m) begin
    if (!rst_n) begin
      rptr <= wptr;
    end else if (fifo_rd_en) begin
      fifo_data_in <= fifo_mem[rptr[9:0]];
      rptr         <= rptr + 1;
    end
  end

  logic [7:0] exp_q [$];

  task automatic fifo_write(input logic [7:0] b);
    fifo_mem[wptr[9:0]] = b;
    wptr = wptr + 1;
    exp_q.push_back(b);
  endtask

  // Bus monitor and scoreboard, sampled half a cycle before the edge that commits each transfer
  int         rd_cnt = 0, acc_cnt = 0, stall_obs = 0, credit_viol = 0;
  int         neg_idx = 0, first_acc_idx = 0, last_acc_idx = 0;
  int         siwu_low = 0, siwu_pulses = 0, siwu_fall_idx = 0;
  logic       siwu_prev = 1'b1;
  logic [7:0] exp_b;

  always @(negedge clk_60m) begin
    neg_idx++;
    if (!rst_n) begin
      rd_cnt = 0; acc_cnt = 0; stall_obs = 0; credit_viol = 0;
      siwu_low = 0; siwu_pulses = 0; siwu_prev = 1'b1;
      exp_q.delete();
    end else begin
      if (fifo_rd_en && (rd_cnt - acc_cnt) >= 3) credit_viol++;
      if (fifo_rd_en) rd_cnt++;
      if (!usb_wr_n && usb_txe_n) stall_obs++;
      if (!usb_wr_n && !usb_txe_n) begin
        if (acc_cnt == 0) first_acc_idx = neg_idx;
        last_acc_idx = neg_idx;
        acc_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL scoreboard_extra: got byte %02h, required none", usb_data_out);
        end else begin
          exp_b = exp_q.pop_front();
          if (usb_data_out !== exp_b) begin
            fails++;
            $display("[TB] FAIL scoreboard_data: got %02h, required %02h", usb_data_out, exp_b);
          end
        end
      end
      if (!usb_siwu_n) begin
        if (siwu_prev) begin
          siwu_pulses++;
          siwu_fall_idx = neg_idx;
        end
        siwu_low++;
      end
      siwu_prev = usb_siwu_n;
    end
  end

  task automatic do_reset();
    tx_enable = 1'b0;
    usb_txe_n = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk_60m);
    #1 rst_n = 1'b1;
    @(posedge clk_60m);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests += 8;
    if (usb_wr_n !== 1'b1)     begin fails++; $display("[TB] FAIL reset_wr_n: got %b, required 1", usb_wr_n); end
    if (usb_siwu_n !== 1'b1)   begin fails++; $display("[TB] FAIL reset_siwu_n: got %b, required 1", usb_siwu_n); end
    if (usb_data_out !== 8'h0) begin fails++; $display("[TB] FAIL reset_data: got %02h, required 00", usb_data_out); end
    if (usb_data_oe !== 1'b0)  begin fails++; $display("[TB] FAIL reset_oe: got %b, required 0", usb_data_oe); end
    if (fifo_rd_en !== 1'b0)   begin fails++; $display("[TB] FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
    if (tx_busy !== 1'b0)      begin fails++; $display("[TB] FAIL reset_busy: got %b, required 0", tx_busy); end
    if ({usb_rd_n, usb_oe_n} !== 2'b11) begin
      fails++; $display("[TB] FAIL reset_rd_oe_n: got %b, required 11", {usb_rd_n, usb_oe_n});
    end
    if ((tx_byte_cnt | tx_stall_cnt) !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_stats: got %0d/%0d, required 0/0", tx_byte_cnt, tx_stall_cnt);
    end
  endtask

  task automatic test_full_rate();
    do_reset();
    for (int i = 0; i < 256; i++) fifo_write(8'(i));
    usb_txe_n = 1'b0;
    tx_enable = 1'b1;
    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge clk_60m);
    repeat (4) @(posedge clk_60m);
    #1;
    tests += 5;
    if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL full_rate_drain: got %0d left, required 0", exp_q.size()); end
    if (acc_cnt != 256) begin fails++; $display("[TB] FAIL full_rate_count: got %0d, required 256", acc_cnt); end
    if (last_acc_idx - first_acc_idx != 255) begin
      fails++; $display("[TB] FAIL full_rate_span: got %0d cycles, required 255", last_acc_idx - first_acc_idx);
    end
    if (credit_viol != 0) begin fails++; $display("[TB] FAIL full_rate_credit: got %0d reads at 3, required 0", credit_viol); end
    if (tx_byte_cnt !== (STATS ? 32'd256 : 32'd0)) begin
      fails++; $display("[TB] FAIL full_rate_byte_cnt: got %0d, required %0d", tx_byte_cnt, STATS ? 256 : 0);
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 128; i++) fifo_write(8'(i));
    usb_txe_n = 1'b0;
    tx_enable = 1'b1;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk_60m);
      #1;
      if (!usb_wr_n && usb_data_out == 8'h40) found = 1'b1;
    end
    usb_txe_n = 1'b1;
    tests++;
    if (!found) begin fails++; $display("[TB] FAIL stall_reach_40: got none, required byte 40 on bus"); end
    repeat (5) begin
      @(negedge clk_60m);
      tests++;
      if (usb_wr_n !== 1'b0 || usb_data_out !== 8'h40) begin
        fails++; $display("[TB] FAIL stall_hold: got wr_n=%b data=%02h, required 0/40", usb_wr_n, usb_data_out);
      end
      @(posedge clk_60m);
      #1;
    end
    usb_txe_n = 1'b0;
    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge clk_60m);
    #1;
    tests += 3;
    if (acc_cnt != 128) begin fails++; $display("[TB] FAIL stall_count: got %0d, required 128", acc_cnt); end
    if (stall_obs != 5) begin fails++; $display("[TB] FAIL stall_cycles: got %0d, required 5", stall_obs); end
    if (tx_stall_cnt !== (STATS ? 32'd5 : 32'd0)) begin
      fails++; $display("[TB] FAIL stall_cnt: got %0d, required %0d", tx_stall_cnt, STATS ? 5 : 0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fifo_write(8'hA5);
    usb_txe_n = 1'b0;
    tx_enable = 1'b1;
    for (int c = 0; c < 100 && siwu_pulses == 0; c++) @(posedge clk_60m);
    #1;
    tests += 2;
    if (acc_cnt != 1) begin fails++; $display("[TB] FAIL flush_accept: got %0d, required 1", acc_cnt); end
    // Accept is seen half a cycle before its edge and SIWU# half a cycle after its edge
    if (siwu_pulses != 1 || siwu_fall_idx - last_acc_idx != int'(FLUSH_CYC) + 1) begin
      fails++; $display("[TB] FAIL flush_delay: got %0d pulses at +%0d, required 1 at +%0d",
                        siwu_pulses, siwu_fall_idx - last_acc_idx, FLUSH_CYC + 1);
    end
    repeat (100) @(posedge clk_60m);
    #1;
    tests += 2;
    if (siwu_low != 1) begin fails++; $display("[TB] FAIL flush_width: got %0d cycles, required 1", siwu_low); end
    if (siwu_pulses != 1) begin fails++; $display("[TB] FAIL flush_repeat: got %0d pulses, required 1", siwu_pulses); end
  endtask

  task automatic test_enable_drop();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) fifo_write(8'(i + 16));
    tx_enable = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk_60m);
      #1;
      if (fifo_rd_en && (rd_cnt - acc_cnt) == 2) found = 1'b1;
    end
    @(posedge clk_60m);
    #1 tx_enable = 1'b0;
    usb_txe_n = 1'b0;
    repeat (40) @(posedge clk_60m);
    #1;
    tests += 4;
    if (!found) begin fails++; $display("[TB] FAIL drop_setup: got no 2+1 fill, required one"); end
    if (acc_cnt != 3) begin fails++; $display("[TB] FAIL drop_accepts: got %0d, required 3", acc_cnt); end
    if (rd_cnt != 3) begin fails++; $display("[TB] FAIL drop_reads: got %0d, required 3", rd_cnt); end
    if ({usb_wr_n, usb_data_oe, tx_busy} !== 3'b100) begin
      fails++; $display("[TB] FAIL drop_idle: got wr_n/oe/busy=%b, required 100", {usb_wr_n, usb_data_oe, tx_busy});
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    for (int i = 0; i < 64; i++) fifo_write(8'(i));
    usb_txe_n = 1'b0;
    tx_enable = 1'b1;
    for (int c = 0; c < 200 && !(acc_cnt >= 10 && !usb_wr_n); c++) begin
      @(posedge clk_60m);
      #1;
    end
    tests++;
    if (usb_wr_n !== 1'b0) begin fails++; $display("[TB] FAIL rst_setup: got wr_n=%b, required 0", usb_wr_n); end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({usb_wr_n, usb_data_oe, usb_siwu_n, fifo_rd_en} !== 4'b1010 || usb_data_out !== 8'h00) begin
      fails++; $display("[TB] FAIL rst_async: got wr/oe/siwu/rd=%b data=%02h, required 1010 00",
                        {usb_wr_n, usb_data_oe, usb_siwu_n, fifo_rd_en}, usb_data_out);
    end
    tx_enable = 1'b0;
    repeat (3) @(posedge clk_60m);
    #1 rst_n = 1'b1;
    @(posedge clk_60m);
    #1;
    for (int i = 0; i < 8; i++) fifo_write(8'hC0 + 8'(i));
    tx_enable = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk_60m);
    #1;
    tests++;
    if (acc_cnt != 8 || exp_q.size() != 0) begin
      fails++; $display("[TB] FAIL rst_resume: got %0d accepts %0d left, required 8 and 0", acc_cnt, exp_q.size());
    end
  endtask

  task automatic test_random_txe();
    int written = 0;
    do_reset();
    tx_enable = 1'b1;
    for (int c = 0; c < 40000 && (written < 10000 || exp_q.size() != 0); c++) begin
      @(posedge clk_60m);
      #1;
      usb_txe_n = 1'($urandom_range(0, 1));
      if (written < 10000 && (wptr - rptr) < 1000) begin
        fifo_write(8'($urandom_range(0, 255)));
        written++;
      end
    end
    usb_txe_n = 1'b0;
    repeat (8) @(posedge clk_60m);
    #1;
    tests += 4;
    if (acc_cnt != 10000 || exp_q.size() != 0) begin
      fails++; $display("[TB] FAIL random_count: got %0d accepts %0d left, required 10000 and 0", acc_cnt, exp_q.size());
    end
    if (credit_viol != 0) begin fails++; $display("[TB] FAIL random_credit: got %0d, required 0", credit_viol); end
    if (tx_byte_cnt !== (STATS ? 32'(acc_cnt) : 32'd0)) begin
      fails++; $display("[TB] FAIL random_byte_cnt: got %0d, required %0d", tx_byte_cnt, STATS ? acc_cnt : 0);
    end
    if (tx_stall_cnt !== (STATS ? 32'(stall_obs) : 32'd0)) begin
      fails++; $display("[TB] FAIL random_stall_cnt: got %0d, required %0d", tx_stall_cnt, STATS ? stall_obs : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_full_rate();
    test_stall();
    test_flush();
    test_enable_drop();
    test_reset_mid_send();
    test_random_txe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
